multicycle_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute controller for the 9-bit ISA. Type is in instr[8:7]: 00 R, 01 M, 10 B, 11 S.
- Owns the PC and the instruction register (IR). Sequences the instruction-memory fetch, data-memory access and register-file writeback.
- Drives the ALU op into the datapath and handles the B/S special cases.
- Sits between the instruction/data memories and the shared datapath. Replaces the purely combinational control for multi-cycle operation.

---
 rtl/multicycle_sequencer_if.sv | 23 ++
 rtl/multicycle_sequencer.sv | 155 +++++++++++++++
 tb/tb_multicycle_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_sequencer_if.sv
// Memory-side bus of the multi-cycle sequencer: instruction fetch and data access handshakes.
// The sequencer is the master; the memory subsystem is the slave.
interface multicycle_sequencer_if #(
    parameter int PC_W = 10
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ready;
    logic [8:0]      imem_data;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ready;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ready, imem_data, dmem_ready
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ready, imem_data, dmem_ready
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the 9-bit ISA (type in instr[8:7]).
// Owns PC, IR and the retired counter; all enables decode from state and IR.
module multicycle_sequencer #(
    parameter int PC_W     = 10,
    parameter int START_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    multicycle_sequencer_if.master  mem,
    output logic [2:0]              alu_op,
    input  logic                    alu_zero,
    output logic                    reg_we,
    output logic [1:0]              wb_sel,
    output logic [8:0]              instr_out,
    output logic [PC_W-1:0]         pc_out,
    output logic                    busy,
    output logic                    halted,
    output logic [CNT_W-1:0]        retired
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT
    } state_t;

    typedef enum logic [1:0] {
        T_R = 2'b00, T_M = 2'b01, T_B = 2'b10, T_S = 2'b11
    } itype_t;

    localparam logic [PC_W-1:0] PC_RESET = PC_W'(START_PC);

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic [8:0]      ir;
    logic [CNT_W-1:0] retired_q;
    logic            ir_load;
    logic            retire;
    logic            restart;
    itype_t          itype;
    logic [PC_W-1:0] branch_off;

    assign itype      = itype_t'(ir[8:7]);
    assign branch_off = {{(PC_W-7){ir[6]}}, ir[6:0]};

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        ir_load      = 1'b0;
        retire       = 1'b0;
        restart      = 1'b0;
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = 2'd0;
        alu_op       = 3'd0;

        // alu_op is only meaningful (and only non-zero) while an instruction is in flight.
        if (state == S_DECODE || state == S_EXEC || state == S_MEM) begin
            unique case (itype)
                T_R:     alu_op = ir[6:4];
                T_B:     alu_op = 3'b001;
                T_M:     alu_op = 3'b000;
                T_S:     alu_op = 3'b000;
            endcase
        end

        unique case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    restart   = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                mem.imem_req = 1'b1;
                if (mem.imem_ready) begin
                    ir_load   = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                unique case (itype)
                    T_R, T_B: state_nxt = S_EXEC;
                    T_M:      state_nxt = S_MEM;
                    T_S: begin
                        // The halt instruction retires here; the PC keeps its address.
                        if (ir[6:0] == 7'h7F) begin
                            retire    = 1'b1;
                            state_nxt = S_HALT;
                        end else begin
                            state_nxt = S_EXEC;
                        end
                    end
                endcase
            end
            S_EXEC: begin
                retire    = 1'b1;
                state_nxt = S_FETCH;
                pc_nxt    = pc + PC_W'(1);
                unique case (itype)
                    T_R: reg_we = 1'b1;
                    T_S: begin
                        reg_we = 1'b1;
                        wb_sel = 2'd2;
                    end
                    T_B: if (alu_zero) pc_nxt = pc + branch_off;
                    T_M: ;
                endcase
            end
            S_MEM: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = ~ir[6];
                if (mem.dmem_ready) begin
                    reg_we    = ir[6];
                    wb_sel    = ir[6] ? 2'd1 : 2'd0;
                    retire    = 1'b1;
                    pc_nxt    = pc + PC_W'(1);
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            pc        <= PC_RESET;
            ir        <= '0;
            retired_q <= '0;
        end else begin
            state <= state_nxt;
            if (ir_load) ir <= mem.imem_data;
            if (restart) begin
                pc        <= PC_RESET;
                retired_q <= '0;
            end else begin
                pc <= pc_nxt;
                if (retire && retired_q != '1) retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign mem.imem_addr = pc;
    assign pc_out        = pc;
    assign instr_out     = ir;
    assign retired       = retired_q;
    assign busy          = (state != S_IDLE) && (state != S_HALT);
    assign halted        = (state == S_HALT);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer: R/M/B/S flows, branch wrap,
// halt/restart and asynchronous reset during a data access.
module tb_multicycle_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  alu_op;
    logic        alu_zero;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic [8:0]  instr_out;
    logic [9:0]  pc_out;
    logic        busy;
    logic        halted;
    logic [15:0] retired;

    int total = 0;
    int bad   = 0;

    multicycle_sequencer_if #(.PC_W(10)) bus ();

    multicycle_sequencer #(.PC_W(10), .START_PC(0), .CNT_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .mem       (bus),
        .alu_op    (alu_op),
        .alu_zero  (alu_zero),
        .reg_we    (reg_we),
        .wb_sel    (wb_sel),
        .instr_out (instr_out),
        .pc_out    (pc_out),
        .busy      (busy),
        .halted    (halted),
        .retired   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Entered in FETCH; returns in DECODE with the new instruction in IR.
    task automatic do_fetch(input logic [8:0] ins, input int nwait, input logic [9:0] exp_pc);
        for (int i = 0; i < nwait; i++) begin
            check("imem_req_wait", 32'(bus.imem_req), 1);
            tick();
        end
        check("imem_req", 32'(bus.imem_req), 1);
        check("imem_addr", 32'(bus.imem_addr), 32'(exp_pc));
        bus.imem_ready = 1'b1;
        bus.imem_data  = ins;
        tick();
        bus.imem_ready = 1'b0;
        bus.imem_data  = 9'h000;
        #1;
        check("ir_loaded", 32'(instr_out), 32'(ins));
        check("decode_no_we", 32'(reg_we), 0);
    endtask

    task automatic run_r(input logic [8:0] ins, input logic [9:0] at_pc,
                         input logic [9:0] exp_pc, input int exp_ret);
        do_fetch(ins, 0, at_pc);
        tick();
        check("r_reg_we", 32'(reg_we), 1);
        check("r_alu_op", 32'(alu_op), 32'(ins[6:4]));
        tick();
        check("r_pc", 32'(pc_out), 32'(exp_pc));
        check("r_retired", 32'(retired), exp_ret);
    endtask

    task automatic run_b(input logic [8:0] ins, input logic zero, input logic [9:0] at_pc,
                         input logic [9:0] exp_pc, input int exp_ret);
        do_fetch(ins, 0, at_pc);
        check("b_alu_op_dec", 32'(alu_op), 1);
        alu_zero = zero;
        tick();
        check("b_no_we", 32'(reg_we), 0);
        check("b_alu_op_exec", 32'(alu_op), 1);
        tick();
        alu_zero = 1'b0;
        check("b_pc", 32'(pc_out), 32'(exp_pc));
        check("b_retired", 32'(retired), exp_ret);
    endtask

    initial begin
        reset_n        = 1'b0;
        start          = 1'b0;
        alu_zero       = 1'b0;
        bus.imem_ready = 1'b0;
        bus.imem_data  = 9'h000;
        bus.dmem_ready = 1'b0;
        tick();
        tick();

        check("rst_busy", 32'(busy), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_pc", 32'(pc_out), 0);
        check("rst_retired", 32'(retired), 0);
        check("rst_imem_req", 32'(bus.imem_req), 0);
        check("rst_dmem_req", 32'(bus.dmem_req), 0);
        check("rst_reg_we", 32'(reg_we), 0);
        check("rst_alu_op", 32'(alu_op), 0);
        check("rst_wb_sel", 32'(wb_sel), 0);
        check("rst_ir", 32'(instr_out), 0);

        reset_n = 1'b1;
        bus.imem_ready = 1'b1;  // stray ready in IDLE must be ignored
        bus.imem_data  = 9'h1FF;
        tick();
        bus.imem_ready = 1'b0;
        bus.imem_data  = 9'h000;
        check("idle_busy", 32'(busy), 0);
        check("idle_ir", 32'(instr_out), 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 1);

        // R: ALU op 011, two wait cycles on fetch.
        do_fetch(9'b00_011_0000, 2, 10'd0);
        check("r1_alu_op_dec", 32'(alu_op), 3);
        tick();
        check("r1_reg_we", 32'(reg_we), 1);
        check("r1_wb_sel", 32'(wb_sel), 0);
        check("r1_alu_op_exec", 32'(alu_op), 3);
        check("r1_pc_exec", 32'(pc_out), 0);
        tick();
        check("r1_we_pulse", 32'(reg_we), 0);
        check("r1_pc", 32'(pc_out), 1);
        check("r1_retired", 32'(retired), 1);

        // Load with dmem_ready in the third MEM cycle; start pulse mid-access ignored.
        do_fetch(9'b01_1_000000, 1, 10'd1);
        check("ld_alu_op", 32'(alu_op), 0);
        tick();
        check("ld_req1", 32'(bus.dmem_req), 1);
        check("ld_we1", 32'(bus.dmem_we), 0);
        check("ld_reg_we1", 32'(reg_we), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ld_req2", 32'(bus.dmem_req), 1);
        check("ld_reg_we2", 32'(reg_we), 0);
        check("ld_pc2", 32'(pc_out), 1);
        tick();
        bus.dmem_ready = 1'b1;
        #1;
        check("ld_req3", 32'(bus.dmem_req), 1);
        check("ld_reg_we3", 32'(reg_we), 1);
        check("ld_wb_sel3", 32'(wb_sel), 1);
        tick();
        bus.dmem_ready = 1'b0;
        #1;
        check("ld_req_drop", 32'(bus.dmem_req), 0);
        check("ld_pc", 32'(pc_out), 2);
        check("ld_retired", 32'(retired), 2);

        // Store completes in its first MEM cycle.
        do_fetch(9'b01_0_000000, 0, 10'd2);
        tick();
        check("st_req", 32'(bus.dmem_req), 1);
        check("st_we", 32'(bus.dmem_we), 1);
        bus.dmem_ready = 1'b1;
        #1;
        check("st_no_reg_we", 32'(reg_we), 0);
        tick();
        bus.dmem_ready = 1'b0;
        check("st_pc", 32'(pc_out), 3);
        check("st_retired", 32'(retired), 3);

        // S (non-halt): immediate writeback.
        do_fetch(9'b11_0000101, 0, 10'd3);
        check("s_alu_op_dec", 32'(alu_op), 0);
        tick();
        check("s_reg_we", 32'(reg_we), 1);
        check("s_wb_sel", 32'(wb_sel), 2);
        tick();
        check("s_pc", 32'(pc_out), 4);
        check("s_retired", 32'(retired), 4);

        run_r(9'b00_111_0000, 10'd4, 10'd5, 5);

        // Branches: not taken, taken backward, wrap below zero.
        run_b(9'b10_1111110, 1'b0, 10'd5, 10'd6, 6);
        run_b(9'b10_1111111, 1'b1, 10'd6, 10'd5, 7);
        run_b(9'b10_1111110, 1'b1, 10'd5, 10'd3, 8);
        run_b(9'b10_1111101, 1'b1, 10'd3, 10'd0, 9);
        run_b(9'b10_1111110, 1'b1, 10'd0, 10'd1022, 10);

        // Sequential wrap from max PC to 0.
        run_r(9'b00_010_0000, 10'd1022, 10'd1023, 11);
        run_r(9'b00_101_0000, 10'd1023, 10'd0, 12);

        // Halt, with a start pulse during DECODE that must be ignored.
        do_fetch(9'b11_1111111, 0, 10'd0);
        start = 1'b1;
        check("halt_dec_busy", 32'(busy), 1);
        tick();
        start = 1'b0;
        check("halt_halted", 32'(halted), 1);
        check("halt_busy", 32'(busy), 0);
        check("halt_pc", 32'(pc_out), 0);
        check("halt_retired", 32'(retired), 13);
        check("halt_imem_req", 32'(bus.imem_req), 0);
        tick();
        check("halt_stays", 32'(halted), 1);

        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_halted", 32'(halted), 0);
        check("restart_busy", 32'(busy), 1);
        check("restart_pc", 32'(pc_out), 0);
        check("restart_retired", 32'(retired), 0);
        check("restart_imem_req", 32'(bus.imem_req), 1);

        run_r(9'b00_001_0000, 10'd0, 10'd1, 1);

        // Asynchronous reset while a load is waiting on dmem_ready.
        do_fetch(9'b01_1_000000, 0, 10'd1);
        tick();
        check("pre_rst_dmem_req", 32'(bus.dmem_req), 1);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_dmem_req", 32'(bus.dmem_req), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_pc", 32'(pc_out), 0);
        check("arst_retired", 32'(retired), 0);
        check("arst_ir", 32'(instr_out), 0);
        bus.dmem_ready = 1'b1;
        #1;
        check("arst_reg_we", 32'(reg_we), 0);
        bus.dmem_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("post_rst_idle", 32'(busy), 0);
        check("post_rst_imem_req", 32'(bus.imem_req), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
